// File: rtl/axi_single_beat_slave.sv
// AXI4 responder backed by a word-addressed RAM. Serves single-beat INCR
// transfers; any other burst shape is drained and answered with SLVERR.
module axi_single_beat_slave #(
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  // write address
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  // write data
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  // write response
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  // read address
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  // read data
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned Offs  = (StrbW > 1) ? $clog2(StrbW) : 0;
  localparam int unsigned IdxW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic [0:0] {RIdle, RData} r_state_e;

  // Anything but a single INCR beat inside the RAM window is an error.
  function automatic logic req_err(input logic [ADDR_WIDTH-1:0] addr,
                                   input logic [7:0] len, input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] idx;
    idx = addr >> Offs;
    return (len != 8'd0) || (burst != BurstIncr) || (64'(idx) >= 64'(DEPTH));
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   wid_q, wid_d;
  logic [IdxW-1:0]       widx_q, widx_d;
  logic [7:0]            wcnt_q, wcnt_d;
  logic                  werr_q, werr_d;
  logic                  mem_we;
  logic                  w_final;
  logic                  aw_err;

  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [7:0]            rcnt_q, rcnt_d;
  logic                  rerr_q, rerr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ar_err;

  assign aw_err  = req_err(awaddr, awlen, awburst);
  assign ar_err  = req_err(araddr, arlen, arburst);
  assign w_final = (wcnt_q == 8'd0);

  // Write FSM next state, handshakes and RAM write enable.
  always_comb begin
    w_state_d = w_state_q;
    wid_d     = wid_q;
    widx_d    = widx_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    mem_we    = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        awready = 1'b1;
        if (awvalid) begin
          wid_d     = awid;
          widx_d    = awaddr[Offs +: IdxW];
          wcnt_d    = awlen;
          werr_d    = aw_err;
          w_state_d = WData;
        end
      end
      WData: begin
        wready = 1'b1;
        if (wvalid) begin
          // A clean request has exactly one beat; a wlast mismatch suppresses it.
          mem_we = !werr_q && wlast && w_final;
          if (wlast != w_final) werr_d = 1'b1;
          wcnt_d = wcnt_q - 8'd1;
          if (w_final) w_state_d = WResp;
        end
      end
      WResp: begin
        bvalid = 1'b1;
        if (bready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  assign bid   = wid_q;
  assign bresp = werr_q ? RespSlverr : RespOkay;

  // Write FSM state and latched request.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= WIdle;
      wid_q     <= '0;
      widx_q    <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      wid_q     <= wid_d;
      widx_q    <= widx_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
    end
  end

  // Byte-enabled RAM write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int b = 0; b < int'(StrbW); b++) begin
        if (wstrb[b]) mem[widx_q][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read FSM next state; RAM is sampled at the AR handshake so a same-cycle
  // write to the same word is not visible to this read.
  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    rcnt_d    = rcnt_q;
    rerr_d    = rerr_q;
    rdata_d   = rdata_q;
    arready   = 1'b0;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    unique case (r_state_q)
      RIdle: begin
        arready = 1'b1;
        if (arvalid) begin
          rid_d     = arid;
          rcnt_d    = arlen;
          rerr_d    = ar_err;
          rdata_d   = ar_err ? '0 : mem[araddr[Offs +: IdxW]];
          r_state_d = RData;
        end
      end
      RData: begin
        rvalid = 1'b1;
        rlast  = (rcnt_q == 8'd0);
        if (rready) begin
          rcnt_d = rcnt_q - 8'd1;
          if (rcnt_q == 8'd0) r_state_d = RIdle;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  assign rid   = rid_q;
  assign rdata = rdata_q;
  assign rresp = rerr_q ? RespSlverr : RespOkay;

  // Read FSM state and held response payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= RIdle;
      rid_q     <= '0;
      rcnt_q    <= '0;
      rerr_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      rcnt_q    <= rcnt_d;
      rerr_q    <= rerr_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi_single_beat_slave.sv
// Scoreboard bench for axi_single_beat_slave: stimulus pushes expected B/R
// responses, a negedge monitor pops them on every handshake.
module tb_axi_single_beat_slave;

  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [7:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [7:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;

  axi_single_beat_slave #(
    .ID_WIDTH(8), .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [7:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t      exp_b[$];
  r_exp_t      exp_r[$];
  logic [31:0] model [int unsigned];
  int          checks = 0;
  int          errors = 0;
  b_exp_t      mon_b;
  r_exp_t      mon_r;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Bounded wait, sampled on negedge: 0 awready, 1 wready, 2 bvalid, 3 arready, 4 rvalid.
  task automatic wait_sig(input int sel, input string name);
    int   n;
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 200) begin
      @(negedge clk);
      n++;
      case (sel)
        0: hit = awready;
        1: hit = wready;
        2: hit = bvalid;
        3: hit = arready;
        default: hit = rvalid;
      endcase
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s timeout actual=0 required=1", name);
    end
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (!rst && bvalid && bready) begin
      if (exp_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected actual bid=%0h required=no response", bid);
      end else begin
        mon_b = exp_b.pop_front();
        check("bid", 64'(bid), 64'(mon_b.id));
        check("bresp", 64'(bresp), 64'(mon_b.resp));
      end
    end
    if (!rst && rvalid && rready) begin
      if (exp_r.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL r_unexpected actual rid=%0h required=no response", rid);
      end else begin
        mon_r = exp_r.pop_front();
        check("rid", 64'(rid), 64'(mon_r.id));
        check("rdata", 64'(rdata), 64'(mon_r.data));
        check("rresp", 64'(rresp), 64'(mon_r.resp));
        check("rlast", 64'(rlast), 64'(mon_r.last));
      end
    end
  end

  function automatic logic is_err(input logic [31:0] addr, input logic [7:0] len,
                                  input logic [1:0] burst);
    return (len != 8'd0) || (burst != 2'b01) || ((addr >> 2) >= DEPTH);
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
    logic [31:0] cur;
    int unsigned word;
    word = addr >> 2;
    cur = model.exists(word) ? model[word] : 32'h0;
    for (int b = 0; b < 4; b++) if (strb[b]) cur[8*b +: 8] = data[8*b +: 8];
    model[word] = cur;
  endtask

  task automatic axi_write(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [31:0] data,
                           input logic [3:0] strb, input int stall);
    logic       err;
    logic [1:0] resp;
    err  = is_err(addr, len, burst);
    resp = err ? 2'b10 : 2'b00;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    wait_sig(0, "aw_accept");
    @(posedge clk); #1;
    awvalid = 1'b0;
    exp_b.push_back('{id, resp});
    for (int i = 0; i <= int'(len); i++) begin
      wdata = (i == 0) ? data : $urandom;
      wstrb = strb;
      wlast = (i == int'(len));
      wvalid = 1'b1;
      wait_sig(1, "w_accept");
      @(posedge clk); #1;
      wvalid = 1'b0;
      wlast = 1'b0;
    end
    if (!err) model_write(addr, data, strb);
    if (stall > 0) begin
      wait_sig(2, "b_valid_stall");
      for (int s = 0; s < stall; s++) begin
        if (s > 0) @(negedge clk);
        check("b_stall_valid", 64'(bvalid), 64'd1);
        check("b_stall_id", 64'(bid), 64'(id));
        check("b_stall_resp", 64'(bresp), 64'(resp));
        check("b_stall_awready", 64'(awready), 64'd0);
      end
      @(posedge clk); #1;
    end
    bready = 1'b1;
    wait_sig(2, "b_valid");
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int stall);
    logic        err;
    logic [1:0]  resp;
    logic [31:0] data;
    err  = is_err(addr, len, burst);
    resp = err ? 2'b10 : 2'b00;
    data = err ? 32'h0 : model[addr >> 2];
    for (int i = 0; i <= int'(len); i++) exp_r.push_back('{id, data, resp, i == int'(len)});
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    wait_sig(3, "ar_accept");
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (i == 0 && stall > 0) begin
        wait_sig(4, "r_valid_stall");
        for (int s = 0; s < stall; s++) begin
          if (s > 0) @(negedge clk);
          check("r_stall_valid", 64'(rvalid), 64'd1);
          check("r_stall_id", 64'(rid), 64'(id));
          check("r_stall_data", 64'(rdata), 64'(data));
          check("r_stall_resp", 64'(rresp), 64'(resp));
          check("r_stall_last", 64'(rlast), 64'(len == 8'd0));
          check("r_stall_arready", 64'(arready), 64'd0);
        end
        @(posedge clk); #1;
      end
      rready = 1'b1;
      wait_sig(4, "r_valid");
      @(posedge clk); #1;
      rready = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  bt;
    int          op;
    int          v;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 64'(awready), 64'd1);
    check("rst_arready", 64'(arready), 64'd1);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rlast", 64'(rlast), 64'd0);
    check("rst_bresp", 64'(bresp), 64'd0);
    check("rst_rresp", 64'(rresp), 64'd0);
    check("rst_bid", 64'(bid), 64'd0);
    check("rst_rid", 64'(rid), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic write then read.
    axi_write(8'h5A, 32'h10, 8'd0, 2'b01, 32'hDEADBEEF, 4'hF, 0);
    axi_read(8'h33, 32'h10, 8'd0, 2'b01, 0);

    // Byte strobes.
    axi_write(8'h01, 32'h20, 8'd0, 2'b01, 32'hFFFFFFFF, 4'hF, 0);
    axi_write(8'h02, 32'h20, 8'd0, 2'b01, 32'h11223344, 4'b0101, 0);
    axi_read(8'h03, 32'h20, 8'd0, 2'b01, 0);

    // Unsupported burst lengths drained with SLVERR; RAM untouched.
    axi_write(8'h04, 32'h10, 8'd3, 2'b01, 32'h12345678, 4'hF, 0);
    axi_read(8'h05, 32'h10, 8'd0, 2'b01, 0);
    axi_read(8'h06, 32'h10, 8'd2, 2'b01, 0);

    // Just past the end of the RAM.
    axi_write(8'h07, DEPTH * 4, 8'd0, 2'b01, 32'h0BADF00D, 4'hF, 0);
    axi_read(8'h08, DEPTH * 4, 8'd0, 2'b01, 0);
    axi_read(8'h09, 32'h10, 8'd0, 2'b01, 0);

    // Back-pressure on B and R.
    axi_write(8'h0A, 32'h40, 8'd0, 2'b01, 32'hA5A55A5A, 4'hF, 5);
    axi_read(8'h0B, 32'h40, 8'd0, 2'b01, 5);
    axi_read(8'h0C, 32'h40, 8'd1, 2'b01, 5);

    // W commit and AR handshake on the same edge, same word: read sees old data.
    awid = 8'h11; awaddr = 32'h10; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
    wait_sig(0, "aw_accept_same");
    @(posedge clk); #1;
    awvalid = 1'b0;
    exp_b.push_back('{8'h11, 2'b00});
    exp_r.push_back('{8'h22, model[32'h10 >> 2], 2'b00, 1'b1});
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    arid = 8'h22; araddr = 32'h10; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1;
    @(negedge clk);
    check("same_edge_wready", 64'(wready), 64'd1);
    check("same_edge_arready", 64'(arready), 64'd1);
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    model_write(32'h10, 32'hCAFEF00D, 4'hF);
    bready = 1'b1;
    wait_sig(2, "b_valid_same");
    @(posedge clk); #1;
    bready = 1'b0;
    rready = 1'b1;
    wait_sig(4, "r_valid_same");
    @(posedge clk); #1;
    rready = 1'b0;
    axi_read(8'h23, 32'h10, 8'd0, 2'b01, 0);

    // Reset in the middle of a write drops it.
    awid = 8'h44; awaddr = 32'h30; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
    wait_sig(0, "aw_accept_rst");
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    check("pre_rst_wready", 64'(wready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_awready", 64'(awready), 64'd1);
    check("post_rst_wready", 64'(wready), 64'd0);
    check("post_rst_bvalid", 64'(bvalid), 64'd0);
    @(posedge clk); #1;
    axi_write(8'h45, 32'h30, 8'd0, 2'b01, 32'h01020304, 4'hF, 0);
    axi_read(8'h46, 32'h30, 8'd0, 2'b01, 0);

    // Randomized traffic over a 16-word pool, low address bits scrambled.
    for (int i = 0; i < 16; i++)
      axi_write(8'($urandom), 32'h100 + 32'(i * 4), 8'd0, 2'b01, $urandom, 4'hF, 0);
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 9);
      a  = 32'h100 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      if (op <= 3) begin
        axi_write(8'($urandom), a, 8'd0, 2'b01, $urandom, 4'($urandom),
                  $urandom_range(0, 2));
      end else if (op <= 7) begin
        axi_read(8'($urandom), a, 8'd0, 2'b01, $urandom_range(0, 2));
      end else begin
        v = $urandom_range(0, 2);
        bt = (v == 0) ? 2'b00 : 2'(v + 1);
        case ($urandom_range(0, 2))
          0: begin
            if (op == 8) axi_write(8'($urandom), a, 8'($urandom_range(1, 3)), 2'b01,
                                   $urandom, 4'hF, 0);
            else         axi_read(8'($urandom), a, 8'($urandom_range(1, 3)), 2'b01, 0);
          end
          1: begin
            if (op == 8) axi_write(8'($urandom), a, 8'd0, bt, $urandom, 4'hF, 0);
            else         axi_read(8'($urandom), a, 8'd0, bt, 0);
          end
          default: begin
            a = DEPTH * 4 + 32'($urandom_range(0, 255) * 4);
            if (op == 8) axi_write(8'($urandom), a, 8'd0, 2'b01, $urandom, 4'hF, 0);
            else         axi_read(8'($urandom), a, 8'($urandom_range(0, 3)), 2'b01, 0);
          end
        endcase
      end
    end

    repeat (3) @(posedge clk);
    check("b_queue_drained", 64'(exp_b.size()), 64'd0);
    check("r_queue_drained", 64'(exp_r.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
